// File: rtl/seq_loader_if.sv
// seq_loader_if: groups the character stream, clear, read port and status
// outputs of seq_loader into one bundle.
//   char_valid_i/char_i/clear_i    : code stream and restart from the converter
//   rd_sel_i/rd_addr_i/rd_data_o   : random-access base read port for the NW engine
//   len_a_o/len_b_o                : stored lengths
//   busy_o/done_o/seq_ready_o      : load progress
//   ovf_o/bad_char_o               : sticky error flags
interface seq_loader_if #(
  parameter int unsigned AW = 5
);
  logic          char_valid_i;
  logic [2:0]    char_i;
  logic          clear_i;
  logic          rd_sel_i;
  logic [AW-1:0] rd_addr_i;
  logic [2:0]    rd_data_o;
  logic [AW-1:0] len_a_o;
  logic [AW-1:0] len_b_o;
  logic          busy_o;
  logic          done_o;
  logic          seq_ready_o;
  logic          ovf_o;
  logic          bad_char_o;

  modport master (
    output char_valid_i, char_i, clear_i, rd_sel_i, rd_addr_i,
    input  rd_data_o, len_a_o, len_b_o, busy_o, done_o, seq_ready_o, ovf_o, bad_char_o
  );

  modport slave (
    input  char_valid_i, char_i, clear_i, rd_sel_i, rd_addr_i,
    output rd_data_o, len_a_o, len_b_o, busy_o, done_o, seq_ready_o, ovf_o, bad_char_o
  );
endinterface

// File: rtl/seq_loader.sv
// seq_loader: assembles sequences A and B from 3-bit nucleotide codes
// ('#'-separated), tracks their lengths and serves bases to the NW engine.
//   clk, rst : clock and synchronous active-high reset
//   bus      : seq_loader_if slave (code stream, clear, read port, status)
module seq_loader #(
  parameter int unsigned MAXLEN = 16,
  parameter int unsigned AW     = 5
) (
  input  logic         clk,
  input  logic         rst,
  seq_loader_if.slave  bus
);
  localparam int unsigned IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_t;

  state_t        state_q;
  logic [AW-1:0] len_a_q, len_b_q;
  logic          busy_q, done_q, seq_ready_q, ovf_q, bad_char_q;
  logic [2:0]    mem_a [MAXLEN];
  logic [2:0]    mem_b [MAXLEN];

  logic is_base, is_sep, accept, full_a, full_b;
  logic in_a, in_b, wr_a, wr_b, drop, bad;

  // Decode the incoming code and derive write/flag strobes.
  always_comb begin
    is_base = 1'b0;
    is_sep  = 1'b0;
    case (bus.char_i)
      3'b001, 3'b110, 3'b100, 3'b011: is_base = 1'b1;
      3'b010:                         is_sep  = 1'b1;
      default:                        ;
    endcase
    accept = bus.char_valid_i & ~bus.clear_i & ~rst;
    full_a = (len_a_q >= AW'(MAXLEN));
    full_b = (len_b_q >= AW'(MAXLEN));
    // IDLE always has len_a == 0, so the first base lands in A[0] via the same path.
    in_a   = (state_q == IDLE) || (state_q == LOAD_A);
    in_b   = (state_q == LOAD_B);
    wr_a   = accept & is_base & in_a & ~full_a;
    wr_b   = accept & is_base & in_b & ~full_b;
    drop   = accept & is_base & ((in_a & full_a) | (in_b & full_b));
    bad    = accept & ~is_base & ~is_sep & (state_q != DONE);
  end

  // Control FSM, lengths and registered status.
  always_ff @(posedge clk) begin
    if (rst || bus.clear_i) begin
      state_q     <= IDLE;
      len_a_q     <= '0;
      len_b_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      seq_ready_q <= 1'b0;
      ovf_q       <= 1'b0;
      bad_char_q  <= 1'b0;
    end else begin
      seq_ready_q <= 1'b0;
      if (wr_a) len_a_q <= len_a_q + AW'(1);
      if (wr_b) len_b_q <= len_b_q + AW'(1);
      if (drop) ovf_q <= 1'b1;
      if (bad)  bad_char_q <= 1'b1;
      if (bus.char_valid_i) begin
        case (state_q)
          IDLE: begin
            if (is_base) begin
              state_q <= LOAD_A;
              busy_q  <= 1'b1;
            end
          end
          LOAD_A: begin
            if (is_sep) state_q <= LOAD_B;
          end
          LOAD_B: begin
            // An empty B is not allowed; '#' only terminates once B has a base.
            if (is_sep && (len_b_q != '0)) begin
              state_q     <= DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              seq_ready_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Base storage; not reset, stale entries are masked on read.
  always_ff @(posedge clk) begin
    if (wr_a) mem_a[len_a_q[IW-1:0]] <= bus.char_i;
    if (wr_b) mem_b[len_b_q[IW-1:0]] <= bus.char_i;
  end

  // Zero-latency read port gated by the selected length.
  logic [AW-1:0] sel_len;
  logic [2:0]    sel_data;
  always_comb begin
    sel_len       = bus.rd_sel_i ? len_b_q : len_a_q;
    sel_data      = bus.rd_sel_i ? mem_b[bus.rd_addr_i[IW-1:0]] : mem_a[bus.rd_addr_i[IW-1:0]];
    bus.rd_data_o = (bus.rd_addr_i < sel_len) ? sel_data : 3'b000;
  end

  assign bus.len_a_o     = len_a_q;
  assign bus.len_b_o     = len_b_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.seq_ready_o = seq_ready_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.bad_char_o  = bad_char_q;
endmodule
